pic_cntrl: RTL and testbench

// - 8-input interrupt controller, PC 8259 style, on the CPU bus clock.
// - Sits directly upstream of the CPU interrupt pins wb_tgc_i/wb_tgc_o.
// - Replaces the hardwired keyboard intr line and the constant vector 9.
// - Gathers timer, keyboard and spare requests, applies mask and fixed priority, and supplies the vector during the CPU acknowledge.
// - I/O slave at ports 0x20/0x21; the top level decodes the address and gates wb_stb_i.

---
 rtl/pic_cntrl_pkg.sv | 26 ++
 rtl/pic_prio_enc.sv | 20 ++
 rtl/pic_cntrl.sv | 132 +++++++++++++
 tb/tb_pic_cntrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_cntrl_pkg.sv
// Shared constants and types for the pic_cntrl interrupt controller.
// EOI command encodings, the spurious irq index and the priority-encoder result.
package pic_cntrl_pkg;

  localparam logic [7:0] PIC_EOI_NS   = 8'h20;
  localparam logic [2:0] PIC_EOI_SP   = 3'b011;
  localparam logic [2:0] PIC_SPUR_IRQ = 3'd7;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } prio_t;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    logic [7:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Specific EOI is 0110_0nnn: top three bits 011, bits [4:3] zero.
  function automatic logic is_specific_eoi(input logic [7:0] code);
    return (code[7:5] == PIC_EOI_SP) && (code[4:3] == 2'b00);
  endfunction

endpackage

// File: rtl/pic_prio_enc.sv
// Lowest-set-bit encoder for 8 bits: bit 0 has the highest priority.
// Returns {valid, idx}; idx is 0 when no bit is set.
module pic_prio_enc
  import pic_cntrl_pkg::*;
(
  input  logic [7:0] bits,
  output prio_t      res
);

  always_comb begin
    res = '0;
    for (int i = 7; i >= 0; i--) begin
      if (bits[i]) begin
        res.valid = 1'b1;
        res.idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/pic_cntrl.sv
// 8-input 8259-style interrupt controller on the CPU bus clock.
// Optional macro PIC_AUTO_EOI_EN: acknowledges never set ISR and EOI writes have no effect.
module pic_cntrl
  import pic_cntrl_pkg::*;
#(
  parameter logic [7:0] VEC_BASE = 8'h08,
  parameter logic [7:0] IMR_RST  = 8'h00
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic [7:0]  irq_i,
  output logic        wb_tgc_o,
  input  logic        wb_tgc_i,
  output logic [7:0]  vec_o
);

  // Bus handshake: a strobed cycle is acked one clock later; the acking edge
  // is the one where stb & cyc are high and ack is still low. The access
  // (write or read capture) takes effect on that same edge. The CPU raises
  // wb_tgc_i (inta) after seeing wb_tgc_o; the rising edge of inta is the
  // acknowledge, and vec_o is held stable for as long as inta stays high.

  logic [7:0] irr;
  logic [7:0] isr;
  logic [7:0] imr;
  logic [7:0] irq_q;
  logic       inta_q;

  logic [7:0] req;
  prio_t      req_p;
  prio_t      isr_p;
  logic       valid;
  logic       ack_edge;
  logic       ack_take;
  logic       bus_acc;
  logic       wr_lo;
  logic       wr_hi;
  logic       rd_acc;

  logic [7:0] irr_set;
  logic [7:0] irr_clr;
  logic [7:0] isr_set;
  logic [7:0] eoi_clr;
  logic [7:0] irr_nxt;
  logic [7:0] isr_nxt;
  logic [7:0] vec_nxt;

  assign req = irr & ~imr;

  pic_prio_enc u_req_enc (
    .bits (req),
    .res  (req_p)
  );

  pic_prio_enc u_isr_enc (
    .bits (isr),
    .res  (isr_p)
  );

  // A request may only interrupt something of strictly lower priority.
  assign valid    = req_p.valid && (!isr_p.valid || (req_p.idx < isr_p.idx));
  assign ack_edge = wb_tgc_i && !inta_q;
  assign ack_take = ack_edge && valid;

  assign bus_acc = wb_stb_i && wb_cyc_i && !wb_ack_o;
  assign wr_lo   = bus_acc && wb_we_i && wb_sel_i[0];
  assign wr_hi   = bus_acc && wb_we_i && wb_sel_i[1];
  assign rd_acc  = bus_acc && !wb_we_i;

  always_comb begin
    irr_set = irq_i & ~irq_q;
    irr_clr = '0;
    isr_set = '0;
    eoi_clr = '0;
    if (ack_take) begin
      irr_clr = onehot8(req_p.idx);
      isr_set = onehot8(req_p.idx);
    end
    if (wr_lo) begin
      if (wb_dat_i[7:0] == PIC_EOI_NS) begin
        if (isr_p.valid) eoi_clr = onehot8(isr_p.idx);
      end else if (is_specific_eoi(wb_dat_i[7:0])) begin
        eoi_clr = onehot8(wb_dat_i[2:0]);
      end
    end
    // A new edge on the bit being acknowledged keeps it pending.
    irr_nxt = (irr & ~irr_clr) | irr_set;
`ifdef PIC_AUTO_EOI_EN
    isr_nxt = '0;
`else
    isr_nxt = (isr & ~eoi_clr) | isr_set;
`endif
    vec_nxt = vec_o;
    if (ack_edge && !valid) begin
      vec_nxt = VEC_BASE + {5'b0, PIC_SPUR_IRQ};
    end else if (!wb_tgc_i && req_p.valid) begin
      vec_nxt = VEC_BASE + {5'b0, req_p.idx};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irr      <= '0;
      isr      <= '0;
      imr      <= IMR_RST;
      irq_q    <= '0;
      inta_q   <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_tgc_o <= 1'b0;
      wb_dat_o <= '0;
      vec_o    <= VEC_BASE + {5'b0, PIC_SPUR_IRQ};
    end else begin
      irr      <= irr_nxt;
      isr      <= isr_nxt;
      irq_q    <= irq_i;
      inta_q   <= wb_tgc_i;
      wb_ack_o <= bus_acc;
      wb_tgc_o <= valid && !wb_tgc_i && !inta_q;
      vec_o    <= vec_nxt;
      if (wr_hi) imr <= wb_dat_i[15:8];
      if (rd_acc) wb_dat_o <= {imr, isr};
    end
  end

endmodule

// File: tb/tb_pic_cntrl.sv
// Self-checking bench for pic_cntrl: directed scenarios plus randomized traffic
// against a bit-array reference model of pending/in-service/mask state.
module tb_pic_cntrl;
  import pic_cntrl_pkg::*;

  localparam logic [7:0] VEC_BASE = 8'h08;
  localparam logic [7:0] IMR_RST  = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic [7:0]  irq_i;
  logic        wb_tgc_o;
  logic        wb_tgc_i;
  logic [7:0]  vec_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_pend;
  logic [7:0] m_isr;
  logic [7:0] m_imr;
  logic [7:0] exp_q[$];

  pic_cntrl #(.VEC_BASE(VEC_BASE), .IMR_RST(IMR_RST)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_ack_o (wb_ack_o),
    .irq_i    (irq_i),
    .wb_tgc_o (wb_tgc_o),
    .wb_tgc_i (wb_tgc_i),
    .vec_o    (vec_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model ----
  function automatic int m_cand();
    for (int i = 0; i < 8; i++)
      if (m_pend[i] && !m_imr[i]) return i;
    return -1;
  endfunction

  function automatic int m_low_isr();
    for (int i = 0; i < 8; i++)
      if (m_isr[i]) return i;
    return 8;
  endfunction

  function automatic logic m_valid();
    int c;
    c = m_cand();
    return (c >= 0) && (c < m_low_isr());
  endfunction

  task automatic m_reset();
    m_pend = '0;
    m_isr  = '0;
    m_imr  = IMR_RST;
  endtask

  task automatic m_eoi(input logic [7:0] code);
`ifndef PIC_AUTO_EOI_EN
    int l;
    if (code == 8'h20) begin
      l = m_low_isr();
      if (l < 8) m_isr[l] = 1'b0;
    end else if (code[7:3] == 5'b01100) begin
      m_isr[code[2:0]] = 1'b0;
    end
`endif
  endtask

  // ---- drivers ----
  task automatic bus_xfer(input logic we, input logic [1:0] sel, input logic [15:0] d,
                          output logic [15:0] rd);
    int n;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we; wb_sel_i = sel; wb_dat_i = d;
    tick();
    n = 0;
    while (!wb_ack_o && n < 4) begin
      tick();
      n++;
    end
    if (!wb_ack_o) check("bus_ack_timeout", 16'(wb_ack_o), 16'h1);
    rd = wb_dat_o;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_sel_i = 2'b00;
    tick();
    check("ack_single", 16'(wb_ack_o), 16'h0);
  endtask

  task automatic wr_imr(input logic [7:0] v);
    logic [15:0] rd;
    bus_xfer(1'b1, 2'b10, {v, 8'h00}, rd);
    m_imr = v;
  endtask

  task automatic wr_cmd(input logic [7:0] code);
    logic [15:0] rd;
    bus_xfer(1'b1, 2'b01, {8'hA5, code}, rd);
    m_eoi(code);
  endtask

  task automatic read_check(input string tag);
    logic [15:0] rd;
    bus_xfer(1'b0, 2'b11, 16'h0, rd);
    check(tag, rd, {m_imr, m_isr});
  endtask

  task automatic pulse_irq(input logic [7:0] bits);
    irq_i = irq_i | bits;
    tick();
    irq_i = irq_i & ~bits;
    m_pend = m_pend | bits;
  endtask

  task automatic settle(input string tag);
    tick();
    tick();
    check(tag, 16'(wb_tgc_o), 16'(m_valid()));
  endtask

  // coll: irq line that rises on the same edge as the acknowledge (0 = none)
  task automatic inta_cycle(input string tag, input logic [7:0] coll);
    int c;
    c = m_cand();
    if (m_valid()) begin
      exp_q.push_back(VEC_BASE + 8'(c));
      m_pend[c] = 1'b0;
`ifndef PIC_AUTO_EOI_EN
      m_isr[c] = 1'b1;
`endif
    end else begin
      exp_q.push_back(VEC_BASE + 8'd7);
    end
    m_pend = m_pend | coll;
    wb_tgc_i = 1'b1;
    irq_i = irq_i | coll;
    tick();
    irq_i = irq_i & ~coll;
    check({tag, "_vec"}, 16'(vec_o), 16'(exp_q.pop_front()));
    check({tag, "_intr_low"}, 16'(wb_tgc_o), 16'h0);
    tick();
    wb_tgc_i = 1'b0;
    tick();
    check({tag, "_intr_after"}, 16'(wb_tgc_o), 16'h0);
    tick();
  endtask

  initial begin
    logic [7:0] r8;
    rst = 1'b1; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0; wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0; irq_i = '0; wb_tgc_i = 1'b0;
    m_reset();
    repeat (3) tick();
    check("rst_ack", 16'(wb_ack_o), 16'h0);
    check("rst_intr", 16'(wb_tgc_o), 16'h0);
    check("rst_vec", 16'(vec_o), 16'(VEC_BASE + 8'd7));
    check("rst_dat", wb_dat_o, 16'h0);
    rst = 1'b0;
    tick();
    read_check("rst_regs");

    // single request: intr two edges after irq is first sampled
    pulse_irq(8'h02);
    check("single_intr_early", 16'(wb_tgc_o), 16'h0);
    tick();
    check("single_intr", 16'(wb_tgc_o), 16'h1);
    check("single_vec_pre", 16'(vec_o), 16'h0009);
    inta_cycle("single", 8'h00);
    check("single_irr", 16'(dut.irr), 16'(m_pend));
    read_check("single_isr");

    // priority and nesting
    pulse_irq(8'h09);
    settle("prio_intr");
    inta_cycle("prio0", 8'h00);
    read_check("prio_isr_a");
    wr_cmd(8'h20);
    read_check("prio_isr_b");
    wr_cmd(8'h20);
    settle("prio_intr3");
    inta_cycle("prio3", 8'h00);
    wr_cmd(8'h63);
    read_check("prio_isr_c");

    // mask
    wr_imr(8'h01);
    pulse_irq(8'h01);
    settle("mask_quiet");
    read_check("mask_read");
    wr_imr(8'h00);
    check("mask_release", 16'(wb_tgc_o), 16'h1);
    inta_cycle("mask", 8'h00);
    wr_cmd(8'h20);

    // spurious acknowledge
    pulse_irq(8'h04);
    settle("spur_intr");
    wr_imr(8'h04);
    inta_cycle("spur", 8'h00);
    read_check("spur_regs");
    wr_imr(8'h00);
    settle("spur_resume");
    inta_cycle("spur_resume", 8'h00);
    wr_cmd(8'h62);

    // edge arriving on the acknowledge edge stays pending
    pulse_irq(8'h01);
    settle("coll_intr");
    inta_cycle("coll", 8'h01);
    check("coll_irr", 16'(dut.irr), 16'(m_pend));
    wr_cmd(8'h20);
    settle("coll_second");
    inta_cycle("coll2", 8'h00);
    wr_cmd(8'h20);

    // held-high line: one request only
    irq_i[4] = 1'b1;
    m_pend[4] = 1'b1;
    settle("held_intr");
    inta_cycle("held", 8'h00);
    wr_cmd(8'h20);
    settle("held_once");
    irq_i[4] = 1'b0;
    tick();

    // reset in the middle of an acknowledge
    pulse_irq(8'h05);
    settle("rstack_intr");
    wb_tgc_i = 1'b1;
    rst = 1'b1;
    tick();
    m_reset();
    check("rstack_irr", 16'(dut.irr), 16'h0);
    check("rstack_intr", 16'(wb_tgc_o), 16'h0);
    check("rstack_vec", 16'(vec_o), 16'(VEC_BASE + 8'd7));
    rst = 1'b0;
    wb_tgc_i = 1'b0;
    tick();
    read_check("rstack_regs");
    settle("rstack_quiet");

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: pulse_irq(8'($urandom_range(1, 255)) & 8'($urandom_range(0, 255)));
        1: wr_imr(8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)));
        2: begin
          case ($urandom_range(0, 2))
            0: r8 = 8'h20;
            1: r8 = {5'b01100, 3'($urandom_range(0, 7))};
            default: r8 = 8'($urandom_range(0, 255));
          endcase
          wr_cmd(r8);
        end
        default: if (wb_tgc_o) inta_cycle("rnd", 8'h00);
      endcase
      settle("rnd_intr");
      read_check("rnd_regs");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
